// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: HI/LO op encodings,
// multiply/divide latencies and the E/M scoreboard slot record.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef struct packed {
    logic       valid;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       epc;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A producer blocks a consumer only if its result arrives later than the consumer needs it.
  function automatic logic slot_hazard(input slot_t s, input logic [4:0] src,
                                       input logic [1:0] tuse);
    return s.valid && (s.wa != 5'd0) && (s.wa == src) && (s.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// HI/LO unit busy counter: loads the op latency when a mult/div issues and
// counts down to zero; busy while nonzero.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_en,
  input  logic [1:0] md_op,
  output logic       busy
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_en && md_op_e'(md_op) == MD_MULT) begin
      count_d = MULT_LAT;
    end else if (start_en && md_op_e'(md_op) == MD_DIV) begin
      count_d = DIV_LAT;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M Tnew scoreboard, HI/LO interlock and eret-after-mtc0
// EPC interlock. Define HAZARD_PERF_CNT_EN to add the stall_cycles counter output.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  Rs_Tuse,
  input  logic [1:0]  Rt_Tuse,
  input  logic        MDen,
  input  logic        D_eret,
  input  logic [4:0]  D_wa,
  input  logic [1:0]  D_tnew,
  input  logic [1:0]  D_md_op,
  input  logic        D_epc_wr,
  input  logic        flush,
  output logic        stall,
  output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  slot_t e_q, e_d, m_q, m_d;
  logic  stall_rs, stall_rt, stall_md, stall_eret;
  logic  md_start_en;

  assign stall_rs   = slot_hazard(e_q, D_rs, Rs_Tuse) | slot_hazard(m_q, D_rs, Rs_Tuse);
  assign stall_rt   = slot_hazard(e_q, D_rt, Rt_Tuse) | slot_hazard(m_q, D_rt, Rt_Tuse);
  assign stall_md   = MDen & md_busy;
  assign stall_eret = D_eret & ((e_q.valid & e_q.epc) | (m_q.valid & m_q.epc));
  assign stall      = stall_rs | stall_rt | stall_md | stall_eret;

  assign md_start_en = ~stall & ~flush;

  // Flush wins over capture; a stalled D turns into a bubble in E.
  always_comb begin
    e_d      = SLOT_EMPTY;
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    if (flush) begin
      m_d.valid = 1'b0;
    end else if (!stall) begin
      e_d = {1'b1, D_wa, D_tnew, D_epc_wr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  md_busy_cnt u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_en (md_start_en),
    .md_op    (D_md_op),
    .busy     (md_busy)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = perf_q + {31'd0, stall};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios plus randomized
// traffic checked against an age-based behavioural model of the pipeline.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, D_wa;
  logic [1:0]  Rs_Tuse, Rt_Tuse, D_tnew, D_md_op;
  logic        MDen, D_eret, D_epc_wr, flush;
  logic        stall, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .Rs_Tuse  (Rs_Tuse),
    .Rt_Tuse  (Rt_Tuse),
    .MDen     (MDen),
    .D_eret   (D_eret),
    .D_wa     (D_wa),
    .D_tnew   (D_tnew),
    .D_md_op  (D_md_op),
    .D_epc_wr (D_epc_wr),
    .flush    (flush),
    .stall    (stall),
    .md_busy  (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    string name;
    bit    stall;
    bit    busy;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: the last two instructions that entered E, youngest first,
  // with remaining Tnew derived from age; HI/LO unit tracked as a free-at cycle.
  typedef struct {
    bit valid;
    int wa;
    int tnew;
    bit epc;
  } ent_t;

  ent_t pipe[$];
  int   cyc        = 0;
  int   md_free_at = 0;

  function automatic void model_clear();
    pipe.delete();
    md_free_at = 0;
  endfunction

  function automatic bit model_busy();
    return md_free_at > cyc;
  endfunction

  function automatic bit src_hazard(int src, int tuse);
    for (int age = 0; age < pipe.size(); age++) begin
      int remain;
      remain = pipe[age].tnew - age;
      if (remain < 0) remain = 0;
      if (pipe[age].valid && pipe[age].wa != 0 && pipe[age].wa == src && remain > tuse)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    bit epc_pending;
    epc_pending = 1'b0;
    foreach (pipe[i]) if (pipe[i].valid && pipe[i].epc) epc_pending = 1'b1;
    return src_hazard(int'(D_rs), int'(Rs_Tuse)) || src_hazard(int'(D_rt), int'(Rt_Tuse)) ||
           (MDen && model_busy()) || (D_eret && epc_pending);
  endfunction

  function automatic void model_edge(bit s);
    ent_t e;
    if (flush) begin
      pipe.delete();
    end else begin
      e.valid = !s;
      e.wa    = int'(D_wa);
      e.tnew  = int'(D_tnew);
      e.epc   = D_epc_wr;
      pipe.push_front(e);
      if (pipe.size() > 2) void'(pipe.pop_back());
      if (!s && D_md_op == 2'b01) md_free_at = cyc + int'(MULT_LAT) + 1;
      if (!s && D_md_op == 2'b10) md_free_at = cyc + int'(DIV_LAT) + 1;
    end
    cyc++;
  endfunction

  // es/eb: hand-derived expectation (0/1) or -1 to take the model's prediction.
  task automatic step(string nm, int es, int eb);
    exp_t x;
    bit   s;
    if (!reset) model_clear();
    s       = model_stall();
    x.name  = nm;
    x.stall = (es < 0) ? s : es[0];
    x.busy  = (eb < 0) ? model_busy() : eb[0];
    sbq.push_back(x);
    @(posedge clk);
    if (reset) model_edge(s);
    else cyc++;
    #1;
  endtask

  task automatic set_idle();
    D_rs = 5'd0; D_rt = 5'd0; Rs_Tuse = 2'd3; Rt_Tuse = 2'd3;
    MDen = 1'b0; D_eret = 1'b0; D_wa = 5'd0; D_tnew = 2'd0;
    D_md_op = 2'd0; D_epc_wr = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    set_idle();
    repeat (12) step("idle", -1, -1);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      n_checks++;
      if (stall === logic'(x.stall)) n_pass++;
      else $display("FAIL %s stall: got %b expected %b (t=%0t)", x.name, stall, x.stall, $time);
      n_checks++;
      if (md_busy === logic'(x.busy)) n_pass++;
      else $display("FAIL %s md_busy: got %b expected %b (t=%0t)", x.name, md_busy, x.busy, $time);
    end
  end

  initial begin
    reset = 1'b0;
    set_idle();
    @(posedge clk); #1;
    step("reset_state", 0, 0);
    D_rs = 5'd1; D_wa = 5'd1; D_tnew = 2'd3; D_md_op = 2'b10; MDen = 1'b1; D_eret = 1'b1;
    step("reset_busy_inputs", 0, 0);
    set_idle();
    reset = 1'b1;
    step("post_reset", 0, 0);

    // load-use with one-cycle bubble
    D_wa = 5'd8; D_tnew = 2'd2;
    step("lw_add_issue", 0, 0);
    D_rs = 5'd8; Rs_Tuse = 2'd1; D_wa = 5'd9; D_tnew = 2'd1;
    step("lw_add_stall", 1, 0);
    step("lw_add_go", 0, 0);
    set_idle();
    step("lw_add_after", 0, 0);
    drain();

    // load-branch needs two bubbles
    D_wa = 5'd8; D_tnew = 2'd2;
    step("lw_beq_issue", 0, 0);
    D_rs = 5'd8; Rs_Tuse = 2'd0; D_wa = 5'd0; D_tnew = 2'd0;
    step("lw_beq_stall1", 1, 0);
    step("lw_beq_stall2", 1, 0);
    step("lw_beq_go", 0, 0);
    drain();

    // register zero never creates a hazard
    D_wa = 5'd0; D_tnew = 2'd2;
    step("r0_issue", 0, 0);
    D_rs = 5'd0; Rs_Tuse = 2'd0; D_rt = 5'd0; Rt_Tuse = 2'd0;
    step("r0_use", 0, 0);
    step("r0_use2", 0, 0);
    drain();

    // rt path
    D_wa = 5'd5; D_tnew = 2'd2;
    step("rt_issue", 0, 0);
    set_idle(); D_rt = 5'd5; Rt_Tuse = 2'd0;
    step("rt_stall1", 1, 0);
    step("rt_stall2", 1, 0);
    step("rt_go", 0, 0);
    drain();

    // divide then mflo
    D_md_op = 2'b10;
    step("div_issue", 0, 0);
    set_idle(); MDen = 1'b1;
    for (int i = 0; i < 10; i++) step("mflo_wait", 1, 1);
    step("mflo_go", 0, 0);
    drain();

    // multiply busy length without a consumer
    D_md_op = 2'b01;
    step("mult_issue", 0, 0);
    set_idle();
    for (int i = 0; i < 5; i++) step("mult_busy", 0, 1);
    step("mult_done", 0, 0);
    drain();

    // mtc0 EPC then eret
    D_epc_wr = 1'b1;
    step("mtc0_issue", 0, 0);
    set_idle(); D_eret = 1'b1;
    step("eret_stall1", 1, 0);
    step("eret_stall2", 1, 0);
    step("eret_go", 0, 0);
    drain();

    // flush while mtc0 sits in E releases the eret
    D_epc_wr = 1'b1;
    step("mtc0f_issue", 0, 0);
    set_idle(); D_eret = 1'b1; flush = 1'b1;
    step("eret_flush", 1, 0);
    flush = 1'b0;
    step("eret_after_flush", 0, 0);
    drain();

    // flush coinciding with a div start does not start the unit
    D_md_op = 2'b10; flush = 1'b1;
    step("div_flushed", 0, 0);
    set_idle();
    step("div_flushed_idle", 0, 0);
    drain();

    // reset in the middle of a divide
    D_md_op = 2'b10;
    step("div2_issue", 0, 0);
    set_idle();
    step("div2_busy1", 0, 1);
    step("div2_busy2", 0, 1);
    reset = 1'b0;
    step("div2_reset", 0, 0);
    reset = 1'b1;
    step("div2_after_reset", 0, 0);
    drain();

    for (int i = 0; i < 500; i++) begin
      D_rs     = 5'($urandom_range(0, 3));
      D_rt     = 5'($urandom_range(0, 3));
      D_wa     = 5'($urandom_range(0, 3));
      Rs_Tuse  = 2'($urandom_range(0, 3));
      Rt_Tuse  = 2'($urandom_range(0, 3));
      D_tnew   = 2'($urandom_range(0, 3));
      MDen     = ($urandom_range(0, 3) == 0);
      D_eret   = ($urandom_range(0, 7) == 0);
      D_epc_wr = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      D_md_op  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      reset    = ($urandom_range(0, 63) != 0);
      step("rand", -1, -1);
    end
    reset = 1'b1;
    drain();

`ifdef HAZARD_PERF_CNT_EN
    D_wa = 5'd8; D_tnew = 2'd2;
    step("perf_lw", 0, 0);
    dut.perf_q = 32'hFFFF_FFFF;
    D_rs = 5'd8; Rs_Tuse = 2'd0; D_wa = 5'd0; D_tnew = 2'd0;
    step("perf_stall1", 1, 0);
    n_checks++;
    if (stall_cycles === 32'h0000_0000) n_pass++;
    else $display("FAIL perf_wrap: got %h expected 00000000", stall_cycles);
    step("perf_stall2", 1, 0);
    n_checks++;
    if (stall_cycles === 32'h0000_0001) n_pass++;
    else $display("FAIL perf_after_wrap: got %h expected 00000001", stall_cycles);
    set_idle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (stall_cycles === 32'h0000_0000) n_pass++;
    else $display("FAIL perf_reset: got %h expected 00000000", stall_cycles);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    drain();
`endif

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
